// File: rtl/shiftreg_frame_serializer.sv
// shiftreg_frame_serializer
// Serialises a static word followed by a dynamic word onto one line, MSB first,
// with a programmable bit period, frame mode select, continuous dynamic
// streaming (MODE 3) and BUSY/DONE/SER_VALID status outputs.
// Optional feature macro: SHIFTREG_PARITY_EN (even parity bit after each
// non-streaming frame). Default build has no parity state or parity logic.
module shiftreg_frame_serializer #(
  parameter int unsigned SIZESRSTAT = 88,
  parameter int unsigned SIZESRDYN  = 16,
  parameter int unsigned DIVW       = 8,
  parameter int unsigned CNTW       = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [1:0]            MODE,
  input  logic [DIVW-1:0]       DIV,
  input  logic [SIZESRSTAT-1:0] STATREG,
  input  logic [SIZESRDYN-1:0]  DYNREG,
  output logic [SIZESRSTAT-1:0] STATLATCH,
  output logic [SIZESRDYN-1:0]  DYNLATCH,
  output logic                  signal_out,
  output logic                  SER_VALID,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [1:0] MODE_BOTH = 2'd0;
  localparam logic [1:0] MODE_STAT = 2'd1;
  localparam logic [1:0] MODE_DYN  = 2'd2;
  localparam logic [1:0] MODE_LOOP = 2'd3;

  localparam logic [CNTW-1:0] LP_STAT_LAST = CNTW'(SIZESRSTAT - 1);
  localparam logic [CNTW-1:0] LP_DYN_LAST  = CNTW'(SIZESRDYN - 1);

`ifdef SHIFTREG_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SH_STAT = 3'd1,
    ST_SH_DYN  = 3'd2,
    ST_END     = 3'd3,
    ST_PARITY  = 3'd4
  } state_t;
  localparam state_t LP_TAIL = ST_PARITY;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SH_STAT = 3'd1,
    ST_SH_DYN  = 3'd2,
    ST_END     = 3'd3
  } state_t;
  localparam state_t LP_TAIL = ST_END;
`endif

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_mode;
  logic [DIVW-1:0]         r_div;
  logic [DIVW-1:0]         r_divcnt;
  logic [CNTW-1:0]         r_bitcnt;
  logic [SIZESRSTAT-1:0]   r_sh_stat;
  logic [SIZESRDYN-1:0]    r_sh_dyn;
`ifdef SHIFTREG_PARITY_EN
  logic                    r_parity;
`endif

  logic w_start;
  logic w_bit_done;
  logic w_last;
  logic w_data_state;
  logic w_repeat;
  logic w_ser_bit;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; STOP overrides any phase/bit advance outside IDLE
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_bit_done   = (r_divcnt == r_div);
    w_last       = w_bit_done && (r_bitcnt == '0);
    w_data_state = (r_state == ST_SH_STAT) || (r_state == ST_SH_DYN);
    w_repeat     = (r_state == ST_SH_DYN) && w_last && (r_mode == MODE_LOOP);
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_start     = 1'b1;
          w_state_nxt = (MODE == MODE_DYN) ? ST_SH_DYN : ST_SH_STAT;
        end
      end
      ST_SH_STAT: begin
        if (w_last) begin
          w_state_nxt = (r_mode == MODE_STAT) ? LP_TAIL : ST_SH_DYN;
        end
      end
      ST_SH_DYN: begin
        if (w_last && (r_mode != MODE_LOOP)) begin
          w_state_nxt = LP_TAIL;
        end
      end
`ifdef SHIFTREG_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = ST_END;
        end
      end
`endif
      ST_END: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (STOP && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Serial output and status decode from the registered state
  always_comb begin
    w_ser_bit = 1'b0;
    SER_VALID = 1'b0;
    BUSY      = (r_state != ST_IDLE);
    DONE      = (r_state == ST_END);
    case (r_state)
      ST_SH_STAT: begin
        w_ser_bit = r_sh_stat[SIZESRSTAT-1];
        SER_VALID = 1'b1;
      end
      ST_SH_DYN: begin
        w_ser_bit = r_sh_dyn[SIZESRDYN-1];
        SER_VALID = 1'b1;
      end
`ifdef SHIFTREG_PARITY_EN
      ST_PARITY: begin
        w_ser_bit = r_parity;
        SER_VALID = 1'b1;
      end
`endif
      default: begin
        w_ser_bit = 1'b0;
        SER_VALID = 1'b0;
      end
    endcase
    signal_out = w_ser_bit;
  end

  // Frame datapath: capture on START, bit-period divider, shifters, bit counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STATLATCH <= '0;
      DYNLATCH  <= '0;
      r_mode    <= '0;
      r_div     <= '0;
      r_divcnt  <= '0;
      r_bitcnt  <= '0;
      r_sh_stat <= '0;
      r_sh_dyn  <= '0;
`ifdef SHIFTREG_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_start) begin
      STATLATCH <= STATREG;
      DYNLATCH  <= DYNREG;
      r_sh_stat <= STATREG;
      r_sh_dyn  <= DYNREG;
      r_mode    <= MODE;
      r_div     <= DIV;
      r_divcnt  <= '0;
      r_bitcnt  <= (MODE == MODE_DYN) ? LP_DYN_LAST : LP_STAT_LAST;
`ifdef SHIFTREG_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (STOP) begin
      r_divcnt <= '0;
      r_bitcnt <= '0;
    end else if (r_state != ST_IDLE && r_state != ST_END) begin
      if (w_bit_done) begin
        r_divcnt <= '0;
        if (r_state == ST_SH_STAT) begin
          r_sh_stat <= {r_sh_stat[SIZESRSTAT-2:0], 1'b0};
        end
        if (r_state == ST_SH_DYN) begin
          r_sh_dyn <= {r_sh_dyn[SIZESRDYN-2:0], 1'b0};
        end
`ifdef SHIFTREG_PARITY_EN
        if (w_data_state) begin
          r_parity <= r_parity ^ w_ser_bit;
        end
`endif
        if (r_bitcnt != '0) begin
          r_bitcnt <= r_bitcnt - CNTW'(1);
        end else if (w_state_nxt == ST_SH_DYN) begin
          r_bitcnt <= LP_DYN_LAST;
        end else begin
          r_bitcnt <= '0;
        end
        // Streaming repeat: the fresh DYNREG sample replaces the shift above
        if (w_repeat) begin
          DYNLATCH <= DYNREG;
          r_sh_dyn <= DYNREG;
        end
      end else begin
        r_divcnt <= r_divcnt + DIVW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_frame_serializer.sv
// Directed testbench for shiftreg_frame_serializer.
// Honours SHIFTREG_PARITY_EN when the design is built with it.
module tb_shiftreg_frame_serializer;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic         STOP;
  logic [1:0]   MODE;
  logic [7:0]   DIV;
  logic [87:0]  STATREG;
  logic [15:0]  DYNREG;
  logic [87:0]  STATLATCH;
  logic [15:0]  DYNLATCH;
  logic         signal_out;
  logic         SER_VALID;
  logic         BUSY;
  logic         DONE;

  int n_checks;
  int n_errors;
  int n_done;

  shiftreg_frame_serializer #(
    .SIZESRSTAT (88),
    .SIZESRDYN  (16),
    .DIVW       (8),
    .CNTW       (7)
  ) u_dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .STOP       (STOP),
    .MODE       (MODE),
    .DIV        (DIV),
    .STATREG    (STATREG),
    .DYNREG     (DYNREG),
    .STATLATCH  (STATLATCH),
    .DYNLATCH   (DYNLATCH),
    .signal_out (signal_out),
    .SER_VALID  (SER_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    if (DONE === 1'b1) n_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  e16;
    logic [87:0]  e88;
    logic [103:0] e104;

    n_checks = 0;
    n_errors = 0;
    n_done   = 0;
    RST_N    = 1'b0;
    START    = 1'b0;
    STOP     = 1'b0;
    MODE     = 2'd0;
    DIV      = 8'd0;
    STATREG  = '0;
    DYNREG   = '0;

    // Reset state
    #1;
    check_val("rst_statlatch", STATLATCH, 0);
    check_val("rst_dynlatch", DYNLATCH, 0);
    check_val("rst_sig", signal_out, 0);
    check_val("rst_valid", SER_VALID, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_done", DONE, 0);
    tick;
    tick;
    RST_N = 1'b1;
    tick;

    // MODE 2, DIV 0, ABCD
    e16    = 16'hABCD;
    MODE   = 2'd2;
    DIV    = 8'd0;
    DYNREG = e16;
    START  = 1'b1;
    tick;
    START  = 1'b0;
    n_done = 0;
    check_val("m2_dynlatch", DYNLATCH, 16'hABCD);
    for (int i = 0; i < 16; i++) begin
      check_val("m2_bit", signal_out, e16[15-i]);
      check_val("m2_valid", SER_VALID, 1);
      tick;
    end
`ifdef SHIFTREG_PARITY_EN
    check_val("m2_par_bit", signal_out, 0);
    check_val("m2_par_valid", SER_VALID, 1);
    check_val("m2_par_nodone", DONE, 0);
    tick;
`endif
    check_val("m2_done", DONE, 1);
    check_val("m2_end_valid", SER_VALID, 0);
    check_val("m2_end_busy", BUSY, 1);
    tick;
    check_val("m2_idle_busy", BUSY, 0);
    check_val("m2_idle_done", DONE, 0);
    check_val("m2_done_count", n_done, 1);

    // MODE 0, DIV 3, static then dynamic; inputs scrambled mid-frame
    e104    = {88'h123456789ABCDEF1234567, 16'hABCD};
    STATREG = 88'h123456789ABCDEF1234567;
    DYNREG  = 16'hABCD;
    MODE    = 2'd0;
    DIV     = 8'd3;
    START   = 1'b1;
    tick;
    START   = 1'b0;
    n_done  = 0;
    STATREG = '0;
    DYNREG  = 16'h0000;
    MODE    = 2'd1;
    DIV     = 8'd0;
    for (int b = 103; b >= 0; b--) begin
      for (int c = 0; c < 4; c++) begin
        check_val("m0_bit", signal_out, e104[b]);
        tick;
      end
    end
`ifdef SHIFTREG_PARITY_EN
    for (int c = 0; c < 4; c++) begin
      check_val("m0_par_bit", signal_out, ^e104);
      tick;
    end
`endif
    check_val("m0_done", DONE, 1);
    check_val("m0_statlatch", STATLATCH, 88'h123456789ABCDEF1234567);
    tick;
    check_val("m0_idle_busy", BUSY, 0);
    check_val("m0_done_count", n_done, 1);

    // MODE 3 streaming with DYNREG change in second repeat, then STOP
    e88     = 88'hFEDCBA9876543210FEDCBA;
    STATREG = e88;
    DYNREG  = 16'hABCD;
    MODE    = 2'd3;
    DIV     = 8'd0;
    START   = 1'b1;
    tick;
    START   = 1'b0;
    n_done  = 0;
    for (int i = 0; i < 88; i++) begin
      check_val("m3_stat_bit", signal_out, e88[87-i]);
      tick;
    end
    for (int r = 0; r < 3; r++) begin
      e16 = (r < 2) ? 16'hABCD : 16'h1234;
      for (int i = 0; i < 16; i++) begin
        if (r == 1 && i == 5) DYNREG = 16'h1234;
        check_val("m3_dyn_bit", signal_out, e16[15-i]);
        tick;
      end
    end
    check_val("m3_rep4_bit", signal_out, 0);
    check_val("m3_rep4_valid", SER_VALID, 1);
    check_val("m3_dynlatch", DYNLATCH, 16'h1234);
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    check_val("m3_stop_busy", BUSY, 0);
    check_val("m3_stop_valid", SER_VALID, 0);
    check_val("m3_stop_sig", signal_out, 0);
    tick;
    check_val("m3_no_done", n_done, 0);

    // Asynchronous reset in the middle of SH_STAT, then a clean frame
    STATREG = 88'h123456789ABCDEF1234567;
    MODE    = 2'd1;
    DIV     = 8'd0;
    START   = 1'b1;
    tick;
    START   = 1'b0;
    n_done  = 0;
    for (int i = 0; i < 9; i++) tick;
    #2;
    RST_N = 1'b0;
    #1;
    check_val("ar_statlatch", STATLATCH, 0);
    check_val("ar_dynlatch", DYNLATCH, 0);
    check_val("ar_sig", signal_out, 0);
    check_val("ar_valid", SER_VALID, 0);
    check_val("ar_busy", BUSY, 0);
    check_val("ar_done", DONE, 0);
    #2;
    RST_N = 1'b1;
    tick;
    e88     = 88'h0F0F00FF55AA33CC96C3E1;
    STATREG = e88;
    START   = 1'b1;
    tick;
    START   = 1'b0;
    check_val("ar_new_latch", STATLATCH, 88'h0F0F00FF55AA33CC96C3E1);
    for (int i = 0; i < 88; i++) begin
      check_val("ar_bit", signal_out, e88[87-i]);
      tick;
    end
`ifdef SHIFTREG_PARITY_EN
    check_val("ar_par_bit", signal_out, ^e88);
    tick;
`endif
    check_val("ar_done_end", DONE, 1);
    tick;
    check_val("ar_idle_busy", BUSY, 0);
    check_val("ar_done_count", n_done, 1);

    // START held high through the whole frame including END
    e16    = 16'h5A3C;
    DYNREG = e16;
    MODE   = 2'd2;
    DIV    = 8'd0;
    START  = 1'b1;
    tick;
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      check_val("sh_bit", signal_out, e16[15-i]);
      tick;
    end
`ifdef SHIFTREG_PARITY_EN
    check_val("sh_par_bit", signal_out, 0);
    tick;
`endif
    check_val("sh_done", DONE, 1);
    tick;
    START = 1'b0;
    check_val("sh_idle_busy", BUSY, 0);
    tick;
    check_val("sh_still_idle", BUSY, 0);
    check_val("sh_done_count", n_done, 1);

    // START and STOP together in IDLE: START wins, STOP then aborts
    STOP   = 1'b1;
    START  = 1'b1;
    n_done = 0;
    tick;
    START  = 1'b0;
    check_val("ss_busy", BUSY, 1);
    check_val("ss_valid", SER_VALID, 1);
    tick;
    STOP   = 1'b0;
    check_val("ss_abort_busy", BUSY, 0);
    check_val("ss_abort_valid", SER_VALID, 0);
    tick;
    check_val("ss_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
